// File: rtl/ghost_mode_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ghost_mode_scheduler                                       |
// | Description : Global ghost mode sequencer. It steps through the          |
// |               scatter/chase phase schedule and runs the frightened       |
// |               interval. It also drives the reverse pulse and the flash   |
// |               indication shared by all ghost movement units.             |
// | Options     : GHOST_COMBO_EN adds i_ghost_eaten / o_combo, a ghost-eaten |
// |               combo counter for the frightened interval.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ghost_mode_scheduler #(
    parameter int          SCATTER_T  = 7,
    parameter int          CHASE_T    = 20,
    parameter int          FRIGHT_T   = 6,
    parameter int          FRIGHT_MIN = 1,
    parameter int          FLASH_T    = 2,
    parameter logic [3:0]  GS_PLAY    = 4'd1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_game_state,
    input  logic [7:0]  i_level,
    input  logic        i_ghost_reload,
    input  logic        i_tick,
    input  logic        i_power_eaten,
`ifdef GHOST_COMBO_EN
    input  logic        i_ghost_eaten,
    output logic [1:0]  o_combo,
`endif
    output logic [1:0]  o_ghost_mode,
    output logic        o_reverse,
    output logic        o_fright_flash,
    output logic [2:0]  o_phase
);

    localparam logic [7:0] SCATTER8   = 8'(SCATTER_T);
    localparam logic [7:0] CHASE8     = 8'(CHASE_T);
    localparam logic [7:0] FRIGHT8    = 8'(FRIGHT_T);
    localparam logic [7:0] FRIGHTMIN8 = 8'(FRIGHT_MIN);
    localparam logic [7:0] FLASH8     = 8'(FLASH_T);

    typedef enum logic [0:0] {
        SCHED  = 1'b0,
        FRIGHT = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  phase_timer;
    logic [7:0]  fright_timer;

    logic        play;
    logic        qtick;
    logic [7:0]  level_eff;
    logic [7:0]  level_m1;
    logic [7:0]  fright_len;
    logic [7:0]  phase_len;
    logic        expire;
    logic        power_ok;
    logic [2:0]  next_phase;

    // Timers only move on ticks that arrive during active play.
    assign play      = (i_game_state == GS_PLAY);
    assign qtick     = play & i_tick;
    assign level_eff = (i_level == 8'd0) ? 8'd1 : i_level;
    assign level_m1  = level_eff - 8'd1;

    // Frightened length shrinks by one tick per level, floored at FRIGHT_MIN.
    always_comb begin
        fright_len = FRIGHTMIN8;
        if ((level_m1 < FRIGHT8) && ((FRIGHT8 - level_m1) >= FRIGHTMIN8))
            fright_len = FRIGHT8 - level_m1;
    end

    // Length of the current phase; later scatter phases are two ticks shorter.
    always_comb begin
        phase_len = CHASE8;
        case (o_phase)
            3'd0, 3'd2: phase_len = SCATTER8;
            3'd4, 3'd6: phase_len = SCATTER8 - 8'd2;
            default:    phase_len = CHASE8;
        endcase
    end

    // Phase 7 is the final, open-ended chase phase and never expires.
    assign expire     = qtick & (state == SCHED) & (o_phase != 3'd7) &
                        (phase_timer == phase_len - 8'd1);
    assign power_ok   = play & i_power_eaten & (fright_len != 8'd0);
    assign next_phase = expire ? (o_phase + 3'd1) : o_phase;

    // Mode FSM with phase/fright timers and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= SCHED;
            phase_timer    <= 8'd0;
            fright_timer   <= 8'd0;
            o_phase        <= 3'd0;
            o_ghost_mode   <= 2'd0;
            o_reverse      <= 1'b0;
            o_fright_flash <= 1'b0;
        end else if (i_ghost_reload) begin
            state          <= SCHED;
            phase_timer    <= 8'd0;
            fright_timer   <= 8'd0;
            o_phase        <= 3'd0;
            o_ghost_mode   <= 2'd0;
            o_reverse      <= 1'b0;
            o_fright_flash <= 1'b0;
        end else if (!play) begin
            o_reverse <= 1'b0;
        end else begin
            // A phase expiry commits even when a power pellet lands in the same cycle.
            if ((state == SCHED) && qtick) begin
                phase_timer <= expire ? 8'd0 : (phase_timer + 8'd1);
                o_phase     <= next_phase;
            end

            if (power_ok) begin
                state          <= FRIGHT;
                fright_timer   <= fright_len;
                o_ghost_mode   <= 2'd2;
                o_fright_flash <= (fright_len <= FLASH8);
            end else if (state == FRIGHT) begin
                if (qtick) begin
                    fright_timer <= fright_timer - 8'd1;
                    if (fright_timer == 8'd1) begin
                        state          <= SCHED;
                        o_ghost_mode   <= {1'b0, o_phase[0]};
                        o_fright_flash <= 1'b0;
                    end else begin
                        o_fright_flash <= ((fright_timer - 8'd1) <= FLASH8);
                    end
                end
            end else begin
                o_ghost_mode <= {1'b0, next_phase[0]};
            end

            // Back-to-back causes collapse into one pulse.
            o_reverse <= (expire | power_ok) & ~o_reverse;
        end
    end

`ifdef GHOST_COMBO_EN
    // Ghost-eaten combo: restarts with each frightened entry, saturates at 3.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_combo <= 2'd0;
        end else if (i_ghost_reload) begin
            o_combo <= 2'd0;
        end else if (power_ok) begin
            o_combo <= 2'd0;
        end else if (play && (state == FRIGHT) && i_ghost_eaten && (o_combo != 2'd3)) begin
            o_combo <= o_combo + 2'd1;
        end
    end
`else
    // No combo tracking in this build.
`endif

endmodule
`default_nettype wire
